// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit holding the HI/LO pair used by mult/div/mthi/mtlo/mfhi/mflo.
// Busy stalls the pipeline from the Start cycle until the result lands in HI/LO.
module mult_div_unit (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        MnDStart_E,
  input  logic [1:0]  MnDOp_E,
  input  logic        MnDWe_E,
  input  logic        MnDHiLo_E,
  input  logic [31:0] A_E,
  input  logic [31:0] B_E,
  output logic        Busy,
  output logic [31:0] HiLoOut
);

  typedef enum logic {ST_IDLE, ST_RUN} state_e;

  localparam logic [3:0] LAT_MUL = 4'd5;
  localparam logic [3:0] LAT_DIV = 4'd10;

  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [1:0]  op_q, op_d;
  logic [3:0]  cnt_q, cnt_d;
  state_e      state;

  logic [63:0] prod_s, prod_u;
  logic        div_signed, a_neg, b_neg;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;
  logic [31:0] res_hi, res_lo;
  logic        res_we;

  assign state = (cnt_q == 4'd0) ? ST_IDLE : ST_RUN;

  // Low 64 bits of the sign-extended product equal the signed 64-bit product.
  assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};

  // Signed divide via magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
  assign div_signed = ~op_q[0];
  assign a_neg      = div_signed & a_q[31];
  assign b_neg      = div_signed & b_q[31];
  assign a_mag      = a_neg ? (32'd0 - a_q) : a_q;
  assign b_mag      = b_neg ? (32'd0 - b_q) : b_q;
  assign q_mag      = (b_mag != 32'd0) ? (a_mag / b_mag) : 32'd0;
  assign r_mag      = (b_mag != 32'd0) ? (a_mag % b_mag) : 32'd0;
  assign quot       = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
  assign rem        = a_neg ? (32'd0 - r_mag) : r_mag;

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    if (!op_q[1]) begin
      res_hi = op_q[0] ? prod_u[63:32] : prod_s[63:32];
      res_lo = op_q[0] ? prod_u[31:0]  : prod_s[31:0];
    end else begin
      res_hi = rem;
      res_lo = quot;
    end
  end

  // Divide by zero still runs the full latency but leaves HI/LO alone.
  assign res_we = (cnt_q == 4'd1) && !(op_q[1] && (b_q == 32'd0));

  always_comb begin
    hi_d  = hi_q;
    lo_d  = lo_q;
    a_d   = a_q;
    b_d   = b_q;
    op_d  = op_q;
    cnt_d = cnt_q;
    case (state)
      ST_IDLE: begin
        if (MnDStart_E) begin
          a_d   = A_E;
          b_d   = B_E;
          op_d  = MnDOp_E;
          cnt_d = MnDOp_E[1] ? LAT_DIV : LAT_MUL;
        end else if (MnDWe_E) begin
          if (MnDHiLo_E) hi_d = A_E;
          else           lo_d = A_E;
        end
      end
      default: begin
        cnt_d = cnt_q - 4'd1;
        if (res_we) begin
          hi_d = res_hi;
          lo_d = res_lo;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi_q  <= 32'd0;
      lo_q  <= 32'd0;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      op_q  <= 2'd0;
      cnt_q <= 4'd0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      a_q   <= a_d;
      b_q   <= b_d;
      op_q  <= op_d;
      cnt_q <= cnt_d;
    end
  end

  assign Busy    = MnDStart_E | (state == ST_RUN);
  assign HiLoOut = MnDHiLo_E ? hi_q : lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: drivers push expected Busy/HiLoOut values into
// queues and a negedge monitor pops and compares them.
module tb_mult_div_unit;

  logic        clk;
  logic        reset_n;
  logic        MnDStart_E;
  logic [1:0]  MnDOp_E;
  logic        MnDWe_E;
  logic        MnDHiLo_E;
  logic [31:0] A_E;
  logic [31:0] B_E;
  logic        Busy;
  logic [31:0] HiLoOut;

  mult_div_unit dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .MnDStart_E (MnDStart_E),
    .MnDOp_E    (MnDOp_E),
    .MnDWe_E    (MnDWe_E),
    .MnDHiLo_E  (MnDHiLo_E),
    .A_E        (A_E),
    .B_E        (B_E),
    .Busy       (Busy),
    .HiLoOut    (HiLoOut)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  string       name_q[$];
  logic [0:0]  exp_busy_q[$];
  logic        chk_read;
  logic        chk_busy;
  int          n_checks;
  int          n_fail;

  always @(negedge clk) begin
    if (chk_busy) begin
      n_checks++;
      if (exp_busy_q.size() == 0) begin
        n_fail++;
        $display("FAIL busy_q_empty: actual=%0b required=queued value", Busy);
      end else begin
        logic [0:0] eb;
        eb = exp_busy_q.pop_front();
        if (Busy !== eb) begin
          n_fail++;
          $display("FAIL busy @%0t: actual=%0b required=%0b", $time, Busy, eb);
        end
      end
    end
    if (chk_read) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL read_q_empty: actual=%08h required=queued value", HiLoOut);
      end else begin
        logic [31:0] ev;
        string       nm;
        ev = exp_q.pop_front();
        nm = name_q.pop_front();
        if (HiLoOut !== ev) begin
          n_fail++;
          $display("FAIL %s: actual=%08h required=%08h", nm, HiLoOut, ev);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_busy(input logic b);
    exp_busy_q.push_back(b);
    chk_busy = 1'b1;
  endtask

  task automatic read_reg(input logic sel, input logic [31:0] ev, input string nm);
    MnDHiLo_E = sel;
    exp_q.push_back(ev);
    name_q.push_back(nm);
    chk_read = 1'b1;
    @(negedge clk);
    #1;
    chk_read = 1'b0;
    tick();
  endtask

  task automatic mt(input logic sel, input logic [31:0] v);
    MnDWe_E   = 1'b1;
    MnDHiLo_E = sel;
    A_E       = v;
    expect_busy(1'b0);
    tick();
    MnDWe_E  = 1'b0;
    chk_busy = 1'b0;
  endtask

  // Start at cycle 0; at cycle inj (if nonzero) a second Start plus mtlo is thrown in.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int lat, input int inj);
    MnDStart_E = 1'b1;
    MnDOp_E    = op;
    A_E        = a;
    B_E        = b;
    expect_busy(1'b1);
    tick();
    for (int i = 1; i <= lat; i++) begin
      MnDStart_E = 1'b0;
      MnDWe_E    = 1'b0;
      A_E        = ~a;
      B_E        = ~b;
      if (i == inj) begin
        MnDStart_E = 1'b1;
        MnDOp_E    = 2'b00;
        A_E        = 32'd2;
        B_E        = 32'd2;
        MnDWe_E    = 1'b1;
        MnDHiLo_E  = 1'b0;
      end
      expect_busy(1'b1);
      tick();
    end
    MnDStart_E = 1'b0;
    MnDWe_E    = 1'b0;
    expect_busy(1'b0);
    tick();
    chk_busy = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks   = 0;
    n_fail     = 0;
    chk_read   = 1'b0;
    chk_busy   = 1'b0;
    reset_n    = 1'b0;
    MnDStart_E = 1'b0;
    MnDOp_E    = 2'b00;
    MnDWe_E    = 1'b0;
    MnDHiLo_E  = 1'b0;
    A_E        = 32'd0;
    B_E        = 32'd0;
    tick();

    // In reset: Busy follows Start, HiLoOut reads zero.
    MnDStart_E = 1'b1;
    expect_busy(1'b1);
    read_reg(1'b1, 32'h0, "reset_hi");
    MnDStart_E = 1'b0;
    expect_busy(1'b0);
    read_reg(1'b0, 32'h0, "reset_lo");
    chk_busy = 1'b0;
    reset_n = 1'b1;

    // mult -2 * 3
    issue(2'b00, 32'hFFFFFFFE, 32'd3, 5, 0);
    read_reg(1'b1, 32'hFFFFFFFF, "mult_hi");
    read_reg(1'b0, 32'hFFFFFFFA, "mult_lo");

    // multu 0xFFFFFFFF * 2
    issue(2'b01, 32'hFFFFFFFF, 32'd2, 5, 0);
    read_reg(1'b1, 32'h00000001, "multu_hi");
    read_reg(1'b0, 32'hFFFFFFFE, "multu_lo");

    // div -7 / 2
    issue(2'b10, 32'hFFFFFFF9, 32'd2, 10, 0);
    read_reg(1'b0, 32'hFFFFFFFD, "div_lo");
    read_reg(1'b1, 32'hFFFFFFFF, "div_hi");

    // div overflow case
    issue(2'b10, 32'h80000000, 32'hFFFFFFFF, 10, 0);
    read_reg(1'b0, 32'h80000000, "div_ovf_lo");
    read_reg(1'b1, 32'h00000000, "div_ovf_hi");

    // mthi/mtlo preload, then divu by zero with a colliding mthi on the Start cycle
    mt(1'b1, 32'h11);
    mt(1'b0, 32'h22);
    read_reg(1'b1, 32'h11, "mthi");
    read_reg(1'b0, 32'h22, "mtlo");
    MnDWe_E   = 1'b1;
    MnDHiLo_E = 1'b1;
    issue(2'b11, 32'd7, 32'd0, 10, 0);
    read_reg(1'b1, 32'h11, "divu0_hi");
    read_reg(1'b0, 32'h22, "divu0_lo");

    // divu 100/7 with Start and mtlo thrown in at cycle 3
    issue(2'b11, 32'd100, 32'd7, 10, 3);
    read_reg(1'b0, 32'd14, "divu_inj_lo");
    read_reg(1'b1, 32'd2, "divu_inj_hi");

    // mult aborted by reset at cycle 2
    MnDStart_E = 1'b1;
    MnDOp_E    = 2'b00;
    A_E        = 32'd3;
    B_E        = 32'd3;
    expect_busy(1'b1);
    tick();
    MnDStart_E = 1'b0;
    expect_busy(1'b1);
    tick();
    reset_n = 1'b0;
    expect_busy(1'b0);
    read_reg(1'b1, 32'h0, "abort_hi");
    chk_busy = 1'b0;
    read_reg(1'b0, 32'h0, "abort_lo");
    reset_n = 1'b1;
    mt(1'b0, 32'd5);
    read_reg(1'b0, 32'd5, "post_reset_mtlo");
    for (int i = 0; i < 6; i++) begin
      expect_busy(1'b0);
      tick();
    end
    chk_busy = 1'b0;
    read_reg(1'b1, 32'h0, "post_reset_hi");
    read_reg(1'b0, 32'd5, "post_reset_lo");

    tick();
    n_checks++;
    if ((exp_q.size() != 0) || (exp_busy_q.size() != 0)) begin
      n_fail++;
      $display("FAIL queues_drained: actual=%0d/%0d required=0/0", exp_q.size(), exp_busy_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
